mc_data_sync_arb: RTL and testbench



---
 rtl/mc_data_sync_arb_pkg.sv | 23 ++
 rtl/mc_data_sync_arb_if.sv | 44 ++++
 rtl/mc_data_sync_arb_data_sync_chan.sv | 98 +++++++++
 rtl/mc_data_sync_arb.sv | 115 +++++++++++
 tb/tb_mc_data_sync_arb.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_data_sync_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_data_sync_arb_pkg
// Description : Shared constants and helpers for the multi-channel data
//               synchroniser / round-robin merger.
//               - EDGE_RISE / EDGE_TOGGLE : TOGGLE_MODE encodings
//               - MIN_NUM_STAGES          : shallowest legal synchroniser
//               - ch_width()              : channel-index width for NUM_CH
// Revision    : 1.0 - initial release
// ============================================================================
package mc_data_sync_arb_pkg;

  localparam int EDGE_RISE      = 0;
  localparam int EDGE_TOGGLE    = 1;
  localparam int MIN_NUM_STAGES = 2;

  // Width of a channel index; never collapses to zero bits.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_data_sync_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_data_sync_arb_if
// Description : Bundle of the per-channel source buses, captured words,
//               status flags and the merged valid/ready stream.
//               slave  : view of the synchroniser block itself
//               master : view of the surrounding logic / testbench
// Signals     : bus_enable, unsync_bus, overrun_clr, out_ready (to block)
//               sync_bus, enable_pulse_d, out_valid, out_data, out_ch,
//               overrun (from block)
// Revision    : 1.0 - initial release
// ============================================================================
interface mc_data_sync_arb_if
  import mc_data_sync_arb_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int BUS_WIDTH = 8
) ();

  localparam int CH_W = ch_width(NUM_CH);

  logic [NUM_CH-1:0]           bus_enable;
  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus;
  logic [NUM_CH*BUS_WIDTH-1:0] sync_bus;
  logic [NUM_CH-1:0]           enable_pulse_d;
  logic                        out_valid;
  logic                        out_ready;
  logic [BUS_WIDTH-1:0]        out_data;
  logic [CH_W-1:0]             out_ch;
  logic [NUM_CH-1:0]           overrun;
  logic [NUM_CH-1:0]           overrun_clr;

  modport slave (
    input  bus_enable, unsync_bus, out_ready, overrun_clr,
    output sync_bus, enable_pulse_d, out_valid, out_data, out_ch, overrun
  );

  modport master (
    output bus_enable, unsync_bus, out_ready, overrun_clr,
    input  sync_bus, enable_pulse_d, out_valid, out_data, out_ch, overrun
  );

endinterface
`default_nettype wire

// File: rtl/mc_data_sync_arb_data_sync_chan.sv
`default_nettype none
// ============================================================================
// Module      : data_sync_chan
// Description : One channel: enable synchroniser, edge detect, capture
//               register, delayed pulse, one-deep pending flag and sticky
//               overrun flag.
// Ports       : clk_i, rst_ni      - clock, async active-low reset
//               enable_i, data_i   - unsynchronised enable and source word
//               grant_i            - arbiter takes this channel's word now
//               overrun_clr_i      - clear the sticky overrun flag
//               sync_data_o        - captured word
//               pulse_d_o          - capture pulse delayed by one cycle
//               pending_o          - a captured word awaits the arbiter
//               overrun_o          - sticky overrun flag
// Revision    : 1.0 - initial release
// ============================================================================
module data_sync_chan
  import mc_data_sync_arb_pkg::*;
#(
  parameter int NUM_STAGES  = MIN_NUM_STAGES,
  parameter int BUS_WIDTH   = 8,
  parameter int TOGGLE_MODE = EDGE_RISE
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic [BUS_WIDTH-1:0] data_i,
  input  logic                 grant_i,
  input  logic                 overrun_clr_i,
  output logic [BUS_WIDTH-1:0] sync_data_o,
  output logic                 pulse_d_o,
  output logic                 pending_o,
  output logic                 overrun_o
);

  logic [NUM_STAGES-1:0] sync_q;
  logic                  edge_q;
  logic                  last;
  logic                  pulse;
  logic                  pulse_d_q;
  logic [BUS_WIDTH-1:0]  data_q;
  logic                  pending_q, pending_d;
  logic                  overrun_q, overrun_d;

  assign last = sync_q[NUM_STAGES-1];

  if (TOGGLE_MODE == EDGE_TOGGLE) begin : g_toggle
    assign pulse = last ^ edge_q;
  end else begin : g_rise
    assign pulse = last & ~edge_q;
  end

  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (overrun_clr_i) begin
      overrun_d = 1'b0;
    end
    // A grant in the same cycle hands the old word out, so overwriting it
    // loses nothing; a set also beats a simultaneous clear.
    if (pulse && pending_q && !grant_i) begin
      overrun_d = 1'b1;
    end
    if (grant_i) begin
      pending_d = 1'b0;
    end
    if (pulse) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= '0;
      edge_q    <= 1'b0;
      pulse_d_q <= 1'b0;
      data_q    <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[NUM_STAGES-2:0], enable_i};
      edge_q    <= last;
      pulse_d_q <= pulse;
      if (pulse) begin
        data_q <= data_i;
      end
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign sync_data_o = data_q;
  assign pulse_d_o   = pulse_d_q;
  assign pending_o   = pending_q;
  assign overrun_o   = overrun_q;

endmodule
`default_nettype wire

// File: rtl/mc_data_sync_arb.sv
`default_nettype none
// ============================================================================
// Module      : mc_data_sync_arb
// Description : NUM_CH independent enable/bus synchronisers whose captured
//               words are merged round-robin onto one registered
//               valid/ready stream.
// Ports       : CLK  - destination clock
//               RST  - asynchronous active-low reset
//               bus  - mc_data_sync_arb_if.slave (source buses, captured
//                      words, pulses, overrun flags, merged stream)
// Revision    : 1.0 - initial release
// ============================================================================
module mc_data_sync_arb
  import mc_data_sync_arb_pkg::*;
#(
  parameter int NUM_STAGES  = 2,
  parameter int BUS_WIDTH   = 8,
  parameter int NUM_CH      = 4,
  parameter int TOGGLE_MODE = EDGE_RISE
) (
  input  logic              CLK,
  input  logic              RST,
  mc_data_sync_arb_if.slave bus
);

  localparam int CH_W = ch_width(NUM_CH);

  logic [NUM_CH-1:0]    pending;
  logic [NUM_CH-1:0]    grant;
  logic [BUS_WIDTH-1:0] chan_data [NUM_CH];

  logic [CH_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]      grant_idx;
  logic                 grant_found;
  logic                 load;

  logic                 out_valid_q, out_valid_d;
  logic [BUS_WIDTH-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]      out_ch_q, out_ch_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    data_sync_chan #(
      .NUM_STAGES  (NUM_STAGES),
      .BUS_WIDTH   (BUS_WIDTH),
      .TOGGLE_MODE (TOGGLE_MODE)
    ) u_chan (
      .clk_i         (CLK),
      .rst_ni        (RST),
      .enable_i      (bus.bus_enable[i]),
      .data_i        (bus.unsync_bus[i*BUS_WIDTH +: BUS_WIDTH]),
      .grant_i       (grant[i]),
      .overrun_clr_i (bus.overrun_clr[i]),
      .sync_data_o   (chan_data[i]),
      .pulse_d_o     (bus.enable_pulse_d[i]),
      .pending_o     (pending[i]),
      .overrun_o     (bus.overrun[i])
    );

    assign bus.sync_bus[i*BUS_WIDTH +: BUS_WIDTH] = chan_data[i];
    assign grant[i] = load && (grant_idx == CH_W'(i));
  end

  // First pending channel at or after rr_ptr, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NUM_CH;
      if (!grant_found && pending[idx]) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'(idx);
      end
    end
  end

  assign load = (!out_valid_q || bus.out_ready) && grant_found;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      // Registered capture value: on a same-cycle re-capture the old word
      // leaves while the new one stays pending.
      out_valid_d = 1'b1;
      out_data_d  = chan_data[grant_idx];
      out_ch_d    = grant_idx;
      rr_ptr_d    = CH_W'((int'(grant_idx) + 1) % NUM_CH);
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_data_sync_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_data_sync_arb
// Description : Self-checking bench. Instance 0 runs rising-edge mode with a
//               2-stage synchroniser, instance 1 toggle mode with 3 stages.
//               A behavioural model per instance predicts every output each
//               cycle; directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_data_sync_arb;
  import mc_data_sync_arb_pkg::*;

  localparam int NCH = 4;
  localparam int BW  = 8;
  localparam int CHW = 2;

  logic CLK;
  logic RST;

  logic [NCH-1:0]    en   [2];
  logic [NCH*BW-1:0] ub   [2];
  logic              rdy  [2];
  logic [NCH-1:0]    clr  [2];

  logic [NCH*BW-1:0] o_sync  [2];
  logic [NCH-1:0]    o_pd    [2];
  logic [NCH-1:0]    o_ovr   [2];
  logic              o_valid [2];
  logic [BW-1:0]     o_data  [2];
  logic [CHW-1:0]    o_ch    [2];

  int n_cmp;
  int n_bad;
  logic [11:0] acc0[$];
  logic [11:0] acc1[$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (inst %0d): got %0h, expected %0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  for (genvar m = 0; m < 2; m++) begin : g_inst
    localparam int NS = (m == 0) ? 2 : 3;
    localparam int TM = (m == 0) ? EDGE_RISE : EDGE_TOGGLE;

    mc_data_sync_arb_if #(.NUM_CH(NCH), .BUS_WIDTH(BW)) ifc ();

    assign ifc.bus_enable  = en[m];
    assign ifc.unsync_bus  = ub[m];
    assign ifc.out_ready   = rdy[m];
    assign ifc.overrun_clr = clr[m];
    assign o_sync[m]  = ifc.sync_bus;
    assign o_pd[m]    = ifc.enable_pulse_d;
    assign o_ovr[m]   = ifc.overrun;
    assign o_valid[m] = ifc.out_valid;
    assign o_data[m]  = ifc.out_data;
    assign o_ch[m]    = ifc.out_ch;

    mc_data_sync_arb #(
      .NUM_STAGES  (NS),
      .BUS_WIDTH   (BW),
      .NUM_CH      (NCH),
      .TOGGLE_MODE (TM)
    ) u_dut (
      .CLK (CLK),
      .RST (RST),
      .bus (ifc)
    );

    // Model state: hist[c][0] is the enable sampled at the latest edge.
    bit          hist   [NCH][NS+1];
    bit [BW-1:0] m_word [NCH];
    bit          m_pend [NCH];
    bit          m_ovr  [NCH];
    bit          m_pd   [NCH];
    bit          cap    [NCH];
    bit          m_valid;
    bit [BW-1:0] m_data;
    int          m_ch;
    int          m_rr;
    int          g;
    int          cc;
    logic [NCH*BW-1:0] exp_sync;
    logic [NCH-1:0]    exp_pd;
    logic [NCH-1:0]    exp_ovr;

    initial begin
      forever begin
        @(posedge CLK or negedge RST);
        if (!RST) begin
          for (int c = 0; c < NCH; c++) begin
            for (int s = 0; s <= NS; s++) hist[c][s] = 1'b0;
            m_word[c] = '0; m_pend[c] = 1'b0; m_ovr[c] = 1'b0; m_pd[c] = 1'b0;
          end
          m_valid = 1'b0; m_data = '0; m_ch = 0; m_rr = 0;
        end else begin
          // Capture happens NS edges after the enable edge is first sampled.
          for (int c = 0; c < NCH; c++) begin
            if (TM == EDGE_TOGGLE) cap[c] = (hist[c][NS-1] != hist[c][NS]);
            else                   cap[c] = hist[c][NS-1] && !hist[c][NS];
          end
          g = -1;
          if (!m_valid || rdy[m]) begin
            for (int k = 0; k < NCH; k++) begin
              cc = (m_rr + k) % NCH;
              if (g < 0 && m_pend[cc]) g = cc;
            end
          end
          if (g >= 0) begin
            m_data = m_word[g]; m_ch = g; m_valid = 1'b1;
            m_pend[g] = 1'b0; m_rr = (g + 1) % NCH;
          end else if (rdy[m]) begin
            m_valid = 1'b0;
          end
          for (int c = 0; c < NCH; c++) begin
            if (cap[c] && m_pend[c]) m_ovr[c] = 1'b1;
            else if (clr[m][c])      m_ovr[c] = 1'b0;
            if (cap[c]) begin
              m_word[c] = ub[m][c*BW +: BW];
              m_pend[c] = 1'b1;
            end
            m_pd[c] = cap[c];
            for (int s = NS; s > 0; s--) hist[c][s] = hist[c][s-1];
            hist[c][0] = en[m][c];
          end
        end
      end
    end

    initial begin
      forever begin
        @(negedge CLK);
        for (int c = 0; c < NCH; c++) begin
          exp_sync[c*BW +: BW] = m_word[c];
          exp_pd[c]  = m_pd[c];
          exp_ovr[c] = m_ovr[c];
        end
        chk("out_valid", m, 64'(o_valid[m]), 64'(m_valid));
        chk("out_data", m, 64'(o_data[m]), 64'(m_data));
        chk("out_ch", m, 64'(o_ch[m]), 64'(m_ch));
        chk("sync_bus", m, 64'(o_sync[m]), 64'(exp_sync));
        chk("enable_pulse_d", m, 64'(o_pd[m]), 64'(exp_pd));
        chk("overrun", m, 64'(o_ovr[m]), 64'(exp_ovr));
      end
    end

    initial begin
      forever begin
        @(posedge CLK);
        if (RST && o_valid[m] && rdy[m]) begin
          if (m == 0) acc0.push_back({2'b00, o_ch[m], o_data[m]});
          else        acc1.push_back({2'b00, o_ch[m], o_data[m]});
        end
      end
    end
  end

  task automatic do_reset();
    RST = 1'b0;
    acc0.delete();
    acc1.delete();
    tick(2);
    RST = 1'b1;
    tick(1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    RST   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      en[i] = '0; ub[i] = '0; rdy[i] = 1'b0; clr[i] = '0;
    end
    tick(3);
    chk("rst_out_valid", 0, 64'(o_valid[0]), 64'd0);
    chk("rst_sync_bus", 0, 64'(o_sync[0]), 64'd0);
    RST = 1'b1;
    tick(1);

    // Single word on ch2.
    ub[0][2*BW +: BW] = 8'hA5; en[0][2] = 1'b1; rdy[0] = 1'b1;
    tick(3);
    chk("t1_pulse_e3", 0, 64'(o_pd[0]), 64'h4);
    chk("t1_valid_e3", 0, 64'(o_valid[0]), 64'd0);
    tick(1);
    chk("t1_pulse_e4", 0, 64'(o_pd[0]), 64'h0);
    chk("t1_valid_e4", 0, 64'(o_valid[0]), 64'd1);
    chk("t1_ch", 0, 64'(o_ch[0]), 64'd2);
    chk("t1_data", 0, 64'(o_data[0]), 64'hA5);
    tick(1);
    chk("t1_valid_after", 0, 64'(o_valid[0]), 64'd0);
    chk("t1_overrun", 0, 64'(o_ovr[0]), 64'd0);
    en[0] = '0;
    tick(4);

    // Round robin from a fresh pointer.
    do_reset();
    ub[0] = 32'h44332211; en[0] = 4'hF;
    tick(4);
    for (int k = 0; k < NCH; k++) begin
      chk("t2_valid", 0, 64'(o_valid[0]), 64'd1);
      chk("t2_ch", 0, 64'(o_ch[0]), 64'(k));
      chk("t2_data", 0, 64'(o_data[0]), 64'((k + 1) * 17));
      tick(1);
    end
    chk("t2_drained", 0, 64'(o_valid[0]), 64'd0);
    en[0] = '0;
    tick(4);
    ub[0] = 32'h88776655; en[0] = 4'hF;
    tick(4);
    chk("t2_burst2_ch", 0, 64'(o_ch[0]), 64'd0);
    chk("t2_burst2_data", 0, 64'(o_data[0]), 64'h55);
    tick(4);
    en[0] = '0;
    tick(4);

    // Backpressure and overrun on ch1.
    rdy[0] = 1'b0; acc0.delete();
    ub[0][0 +: BW] = 8'h99; en[0][0] = 1'b1;
    tick(2);
    ub[0][BW +: BW] = 8'h10; en[0][1] = 1'b1;
    tick(5);
    en[0][1] = 1'b0;
    tick(3);
    ub[0][BW +: BW] = 8'h20; en[0][1] = 1'b1;
    tick(5);
    chk("t3_overrun_set", 0, 64'(o_ovr[0][1]), 64'd1);
    rdy[0] = 1'b1;
    tick(6);
    chk("t3_words", 0, 64'(acc0.size()), 64'd2);
    if (acc0.size() == 2) begin
      chk("t3_word0", 0, 64'(acc0[0]), 64'h099);
      chk("t3_word1", 0, 64'(acc0[1]), 64'h120);
    end
    clr[0][1] = 1'b1;
    tick(1);
    clr[0][1] = 1'b0;
    chk("t3_overrun_clr", 0, 64'(o_ovr[0][1]), 64'd0);
    en[0] = '0;
    tick(5);

    // Stall stability while ch3 captures.
    rdy[0] = 1'b0;
    ub[0][0 +: BW] = 8'h77; en[0][0] = 1'b1;
    tick(5);
    ub[0][3*BW +: BW] = 8'hBB; en[0][3] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk("t4_stall_valid", 0, 64'(o_valid[0]), 64'd1);
      chk("t4_stall_data", 0, 64'(o_data[0]), 64'h77);
      chk("t4_stall_ch", 0, 64'(o_ch[0]), 64'd0);
    end
    rdy[0] = 1'b1;
    tick(1);
    chk("t4_next_ch", 0, 64'(o_ch[0]), 64'd3);
    chk("t4_next_data", 0, 64'(o_data[0]), 64'hBB);
    tick(3);
    en[0] = '0;
    tick(5);

    // Toggle mode on instance 1.
    acc1.delete(); rdy[1] = 1'b1;
    ub[1][0 +: BW] = 8'h5A; en[1][0] = 1'b1;
    tick(6);
    ub[1][0 +: BW] = 8'hC3; en[1][0] = 1'b0;
    tick(8);
    chk("t5_words", 1, 64'(acc1.size()), 64'd2);
    if (acc1.size() == 2) begin
      chk("t5_word0", 1, 64'(acc1[0]), 64'h05A);
      chk("t5_word1", 1, 64'(acc1[1]), 64'h0C3);
    end
    chk("t5_overrun", 1, 64'(o_ovr[1]), 64'd0);

    // Asynchronous reset with a word out and two pending.
    rdy[0] = 1'b0;
    ub[0] = 32'h00030201; en[0] = 4'b0111;
    tick(5);
    chk("t6_valid_before", 0, 64'(o_valid[0]), 64'd1);
    @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    chk("t6_async_valid", 0, 64'(o_valid[0]), 64'd0);
    chk("t6_async_data", 0, 64'(o_data[0]), 64'd0);
    chk("t6_async_sync", 0, 64'(o_sync[0]), 64'd0);
    en[0] = '0; acc0.delete(); acc1.delete();
    tick(2);
    RST = 1'b1; rdy[0] = 1'b1;
    tick(10);
    chk("t6_no_stale", 0, 64'(acc0.size()), 64'd0);

    // Random traffic, with a stretch of heavy backpressure.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (n >= 200 && n < 320) rdy[i] = ($urandom_range(0, 7) == 0);
        else                     rdy[i] = ($urandom_range(0, 3) != 0);
        for (int c = 0; c < NCH; c++) begin
          if ($urandom_range(0, 5) == 0) en[i][c] = ~en[i][c];
        end
        ub[i]  = $urandom;
        clr[i] = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '0;
      end
      tick(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
